cond_split_pipe: RTL and testbench
==================================

# cond_split_pipe

Multi-lane, parametrised successor to the single-lane conditional split register. Each accepted beat carries CHANNELS lanes of WIDTH-bit data plus one condition bit per lane. Every lane produces two results, A and B, each formed by adding a cond-selected signed offset to the lane data, with a runtime wrap or saturate mode. Results travel through a DEPTH-stage elastic valid/ready pipeline, and a sticky counter records saturation events for software.

## Interface
- WIDTH, 8: lane data width (≥2)
- CHANNELS, 1: number of lanes (≥1)
- DEPTH, 1: pipeline stages from input to output (≥1)
- OFS_A_T, 0: signed offset for A when cond=1
- OFS_A_F, -1: signed offset for A when cond=0
- OFS_B_T, 3: signed offset for B when cond=1
- OFS_B_F, -2: signed offset for B when cond=0
- Offsets are limited to the range −2^(WIDTH−1) .. 2^(WIDTH−1)−1.

Ports:
- clk, input, 1: clock
- reset, input, 1: asynchronous, active-high reset
- in_valid, input, 1: input beat valid
- in_ready, output, 1: input beat accepted when in_valid && in_ready
- in_cond, input, CHANNELS: per-lane condition bit
- in_data, input, CHANNELS*WIDTH: lane data; lane i occupies bits [i*WIDTH +: WIDTH]
- sat_en, input, 1: 1 = saturate, 0 = wrap; sampled at accept
- flush, input, 1: synchronous pipeline drop
- out_valid, output, 1: output beat valid
- out_ready, input, 1: downstream accepts the output beat
- out_a, output, CHANNELS*WIDTH: A results, packed like in_data
- out_b, output, CHANNELS*WIDTH: B results, packed like in_data
- sat_count, output, 16: saturation event count
- sat_clr, input, 1: synchronous clear of sat_count

## Operation
**Arithmetic (per lane, per result)**
- Form the sum as data zero-extended to WIDTH+2 bits plus the selected offset sign-extended to WIDTH+2 bits.
- Wrap mode: result is sum[WIDTH−1:0].
- Saturate mode: sum < 0 gives 0; sum > 2^WIDTH−1 gives 2^WIDTH−1; otherwise the low WIDTH bits.
- A clamp event occurs only when saturation actually changes the value. In wrap mode there are no events.

**Where computation happens**
- Results are computed combinationally from in_* and registered into stage 0 on accept.
- Stages 1..DEPTH−1 are pure delay, each with its own valid bit.
- The last stage drives out_*.

**Elastic pipeline**
- Stage k advances when it is empty or stage k+1 advances. The last stage advances when it is empty or out_ready=1.
- in_ready = stage-0 advance && !flush && !reset.
- At full occupancy the pipeline sustains 1 beat/cycle.
- No beat is lost, duplicated or reordered under any out_ready pattern.
- A stage's data holds while its valid bit is set and the stage is stalled.

**Flush**
- flush=1 clears all valid bits at the next edge.
- No input is accepted during the flush cycle.
- Data registers may keep stale values.

**Saturation counter**
- On each accept, sat_count increases by the number of clamp events in the beat (0..2*CHANNELS).
- The counter saturates at 0xFFFF.
- sat_clr has priority: the count becomes 0 and that cycle's events are dropped.
- Flushed beats remain counted.

**Reset**
- out_valid=0, all stage valid bits 0, out_a=0, out_b=0, sat_count=0, in_ready=0 while reset is held.
- in_ready=1 from the first cycle after release when out_ready is irrelevant (pipeline empty).

## Timing
- Latency: a beat accepted at edge n is presented on out_* after edge n+DEPTH−1, i.e. visible DEPTH cycles after the input is presented, when there is no stall.
- in_ready is combinational from out_ready through the stage-advance chain. There is no skid buffer.
- Reset asserted mid-stream empties the pipeline immediately (asynchronous). Partial beats are not recovered.
- flush and an output handshake in the same cycle: the output beat counts as delivered, then the pipeline is empty.
- With the default parameters (CHANNELS=1, DEPTH=1, default offsets) the block matches the legacy behaviour: a=data or data−1, b=data+3 or data−2.

## Test plan
All scenarios use WIDTH=8, CHANNELS=2, DEPTH=3, default offsets.

1. **Reset values.** Assert reset mid-stream with 3 beats in flight -> out_valid=0, out_a=out_b=0, sat_count=0, in_ready=0 during reset. After release, in_ready=1 and no stale beat emerges.
2. **Wrap mode.** sat_en=0, lane0 cond=1 data=0xFE, lane1 cond=0 data=0x00 -> 3 cycles later lane0 a=0xFE b=0x01, lane1 a=0xFF b=0xFE; sat_count=0.
3. **Saturate mode.** Same stimulus with sat_en=1 -> lane0 a=0xFE b=0xFF, lane1 a=0x00 b=0x00; sat_count=3.
4. **Backpressure.** Stream 8 beats with incrementing data 0x10..0x17 and out_ready=0 for cycles 4–7 -> in_ready drops once 3 stages are full; output sequence is exactly 0x10..0x17 in order, no gaps while out_ready=1.
5. **Flush.** Load 3 beats, then pulse flush with out_ready=0 -> out_valid=0 next cycle, in_ready=0 during the flush cycle, nothing emerges; the next beat appears after 3 cycles.
6. **Counter limits.** Run 16384 saturate beats, all lanes with cond=0 and data=0x00 (4 events/beat) -> sat_count=0xFFFF and holds on further beats. Assert sat_clr together with an event beat -> sat_count=0.

Source files
------------

// File: rtl/cond_split_pipe.sv
// Multi-lane conditional split: per-lane A/B results from cond-selected offsets,
// wrap or saturate, carried through a DEPTH-stage elastic valid/ready pipeline.
module cond_split_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 1,
  parameter int DEPTH    = 1,
  parameter int OFS_A_T  = 0,
  parameter int OFS_A_F  = -1,
  parameter int OFS_B_T  = 3,
  parameter int OFS_B_F  = -2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS-1:0]       in_cond,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      sat_en,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_a,
  output logic [CHANNELS*WIDTH-1:0] out_b,
  output logic [15:0]               sat_count,
  input  logic                      sat_clr
);

  localparam int SW = WIDTH + 2;
  localparam int CW = CHANNELS * WIDTH;

  localparam logic [SW-1:0] OA_T = SW'(OFS_A_T);
  localparam logic [SW-1:0] OA_F = SW'(OFS_A_F);
  localparam logic [SW-1:0] OB_T = SW'(OFS_B_T);
  localparam logic [SW-1:0] OB_F = SW'(OFS_B_F);

  // Returns {clamp_event, result}; sum can never reach 2^(WIDTH+1), so bit WIDTH flags overflow.
  function automatic logic [WIDTH:0] arith(input logic [WIDTH-1:0] d,
                                           input logic [SW-1:0]    ofs,
                                           input logic             sat);
    logic [SW-1:0] sum;
    sum = {2'b00, d} + ofs;
    if (!sat)             return {1'b0, sum[WIDTH-1:0]};
    else if (sum[SW-1])   return {1'b1, {WIDTH{1'b0}}};
    else if (sum[WIDTH])  return {1'b1, {WIDTH{1'b1}}};
    else                  return {1'b0, sum[WIDTH-1:0]};
  endfunction

  logic [DEPTH-1:0] valid_q;
  logic [CW-1:0]    a_q [DEPTH];
  logic [CW-1:0]    b_q [DEPTH];
  logic [15:0]      cnt_q;
  logic [15:0]      cnt_d;
  logic [CW-1:0]    a_d;
  logic [CW-1:0]    b_d;
  logic [15:0]      evt_d;
  logic [DEPTH-1:0] adv;
  logic             accept;

  always_comb begin
    logic [WIDTH:0] ra;
    logic [WIDTH:0] rb;
    logic [16:0]    cnt_sum;
    a_d   = '0;
    b_d   = '0;
    evt_d = '0;
    for (int l = 0; l < CHANNELS; l++) begin
      ra = arith(in_data[l*WIDTH +: WIDTH], in_cond[l] ? OA_T : OA_F, sat_en);
      rb = arith(in_data[l*WIDTH +: WIDTH], in_cond[l] ? OB_T : OB_F, sat_en);
      a_d[l*WIDTH +: WIDTH] = ra[WIDTH-1:0];
      b_d[l*WIDTH +: WIDTH] = rb[WIDTH-1:0];
      evt_d = evt_d + 16'(ra[WIDTH]) + 16'(rb[WIDTH]);
    end
    cnt_sum = {1'b0, cnt_q} + {1'b0, evt_d};
    cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  // Stage k can move unless it and every stage after it is full and the sink is stalled.
  always_comb begin
    logic tail_full;
    tail_full = 1'b1;
    adv       = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      tail_full = tail_full & valid_q[k];
      adv[k]    = !tail_full || out_ready;
    end
  end

  assign in_ready = adv[0] && !flush && !reset;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      if (sat_clr)     cnt_q <= '0;
      else if (accept) cnt_q <= cnt_d;

      if (flush) begin
        valid_q <= '0;
      end else begin
        if (adv[0]) valid_q[0] <= accept;
        for (int k = 1; k < DEPTH; k++) begin
          if (adv[k]) valid_q[k] <= valid_q[k-1];
        end
      end

      if (accept) begin
        a_q[0] <= a_d;
        b_q[0] <= b_d;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k] && valid_q[k-1]) begin
          a_q[k] <= a_q[k-1];
          b_q[k] <= b_q[k-1];
        end
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_a     = a_q[DEPTH-1];
  assign out_b     = b_q[DEPTH-1];
  assign sat_count = cnt_q;

endmodule

// File: tb/tb_cond_split_pipe.sv
// Scoreboard bench for cond_split_pipe with WIDTH=8, CHANNELS=2, DEPTH=3.
module tb_cond_split_pipe;
  localparam int W  = 8;
  localparam int C  = 2;
  localparam int D  = 3;
  localparam int CW = C * W;

  typedef struct packed {
    logic [CW-1:0] a;
    logic [CW-1:0] b;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [C-1:0]  in_cond = '0;
  logic [CW-1:0] in_data = '0;
  logic          sat_en = 1'b0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [CW-1:0] out_a;
  logic [CW-1:0] out_b;
  logic [15:0]   sat_count;
  logic          sat_clr = 1'b0;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   mcnt = 0;
  int   n_pop = 0;
  bit   acc;

  cond_split_pipe #(.WIDTH(W), .CHANNELS(C), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_cond(in_cond), .in_data(in_data), .sat_en(sat_en), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .sat_count(sat_count), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lane(input int s, input bit sat, inout int ev);
    if (!sat) return s & 255;
    if (s < 0) begin ev++; return 0; end
    if (s > 255) begin ev++; return 255; end
    return s;
  endfunction

  function automatic void model(input logic [C-1:0] cond, input logic [CW-1:0] data,
                                input bit sat, output exp_t e, output int ev);
    ev = 0;
    e  = '0;
    for (int l = 0; l < C; l++) begin
      int d;
      d = int'(data[l*W +: W]);
      e.a[l*W +: W] = 8'(lane(d + (cond[l] ? 0 : -1), sat, ev));
      e.b[l*W +: W] = 8'(lane(d + (cond[l] ? 3 : -2), sat, ev));
    end
  endfunction

  // One clock: observe at the falling edge, update the model, return 1 unit past the rising edge.
  task automatic step();
    exp_t e;
    int   ev;
    @(negedge clk);
    chk("sat_count", 32'(sat_count), 32'(mcnt));
    if (sbq.size() == 0) begin
      chk("idle_valid", 32'(out_valid), 0);
    end else if (out_valid && out_ready) begin
      e = sbq.pop_front();
      n_pop++;
      chk("out_a", 32'(out_a), 32'(e.a));
      chk("out_b", 32'(out_b), 32'(e.b));
    end
    acc = in_valid && in_ready;
    ev  = 0;
    if (acc) begin
      model(in_cond, in_data, sat_en, e, ev);
      sbq.push_back(e);
    end
    if (sat_clr) mcnt = 0;
    else if (acc) mcnt = (mcnt + ev > 65535) ? 65535 : mcnt + ev;
    if (flush) sbq.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [C-1:0] cond, input logic [W-1:0] d1, input logic [W-1:0] d0);
    in_valid = 1'b1;
    in_cond  = cond;
    in_data  = {d1, d0};
  endtask

  initial begin
    int sent, pop0, gaps;
    bit stall_seen;

    // Reset held from time zero
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_a", 32'(out_a), 0);
    chk("rst_sat_count", 32'(sat_count), 0);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 1);

    // Scenario 1: reset mid-stream with 3 beats in flight (counting events)
    out_ready = 1'b0;
    sat_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 8'h00, 8'(i));
      step();
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_out_a", 32'(out_a), 0);
    chk("mid_rst_out_b", 32'(out_b), 0);
    chk("mid_rst_sat_count", 32'(sat_count), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    sbq.delete();
    mcnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    repeat (5) step();

    // Scenario 2: wrap mode, 3-cycle latency
    sat_en = 1'b0;
    drive(2'b01, 8'h00, 8'hFE);
    step();
    in_valid = 1'b0;
    step();
    chk("wrap_early_valid", 32'(out_valid), 0);
    step();
    chk("wrap_valid", 32'(out_valid), 1);
    chk("wrap_a", 32'(out_a), 32'h0000_FFFE);
    chk("wrap_b", 32'(out_b), 32'h0000_FE01);
    step();
    chk("wrap_cnt", 32'(sat_count), 0);

    // Scenario 3: saturate mode
    sat_en = 1'b1;
    drive(2'b01, 8'h00, 8'hFE);
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("sat_valid", 32'(out_valid), 1);
    chk("sat_a", 32'(out_a), 32'h0000_00FE);
    chk("sat_b", 32'(out_b), 32'h0000_00FF);
    chk("sat_cnt", 32'(sat_count), 3);
    step();

    // Scenario 4: backpressure with out_ready low for cycles 4..7
    sat_en = 1'b0;
    sent = 0;
    gaps = 0;
    stall_seen = 1'b0;
    pop0 = n_pop;
    for (int cyc = 0; cyc < 60 && (sent < 8 || sbq.size() > 0); cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 7);
      in_valid  = (sent < 8);
      in_cond   = 2'b11;
      in_data   = {8'(8'h10 + sent), 8'(8'h10 + sent)};
      #1;
      if (in_valid && !in_ready) stall_seen = 1'b1;
      if (n_pop > pop0 && sbq.size() > 0 && out_ready && !out_valid) gaps++;
      step();
      if (acc) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_stall_seen", 32'(stall_seen), 1);
    chk("bp_delivered", 32'(n_pop - pop0), 8);
    chk("bp_gaps", 32'(gaps), 0);

    // Scenario 5: flush with 3 beats loaded and sink stalled
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 8'(8'h40 + i), 8'(8'h50 + i));
      step();
    end
    drive(2'b10, 8'h77, 8'h66);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 0);
    step();
    chk("flush_no_accept", 32'(acc), 0);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    repeat (4) step();
    drive(2'b01, 8'h33, 8'h22);
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("post_flush_valid", 32'(out_valid), 1);
    step();

    // Scenario 6: counter saturation and clear priority
    sat_en = 1'b1;
    drive(2'b00, 8'h00, 8'h00);
    repeat (16384) step();
    chk("cnt_max", 32'(sat_count), 32'h0000_FFFF);
    repeat (4) step();
    chk("cnt_hold", 32'(sat_count), 32'h0000_FFFF);
    sat_clr = 1'b1;
    step();
    sat_clr  = 1'b0;
    in_valid = 1'b0;
    chk("cnt_clr", 32'(sat_count), 0);
    repeat (6) step();
    chk("sb_empty", 32'(sbq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
